// File: rtl/serial_mag_comp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package serial_mag_comp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_mag_comp_cmp_bit_cell.sv
// One-bit equality / greater-than cell.
module cmp_bit_cell (
    input  logic x,
    input  logic y,
    output logic e,
    output logic g
);

    assign e = (~x & ~y) | (x & y);
    assign g = x & ~y;

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned comparator: MSB first, exits at the first differing bit.
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             bit_e, bit_g;

    cmp_bit_cell u_cell (
        .x (sa_q[WIDTH-1]),
        .y (sb_q[WIDTH-1]),
        .e (bit_e),
        .g (bit_g)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bit_e) begin
                    eq_d    = 1'b0;
                    gt_d    = bit_g;
                    lt_d    = sb_q[WIDTH-1];
                    state_d = DONE;
                end else if (cnt_q == CW'(1)) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    sa_d  = {sa_q[WIDTH-2:0], 1'b0};
                    sb_d  = {sb_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Bit-serial magnitude comparator for two WIDTH-bit unsigned words.
- Accepts a word pair over a valid/ready handshake and examines one bit pair per clock, MSB first, using a 1-bit equality/greater cell.
- Stops early at the first differing bit and returns a one-hot eq/gt/lt result over a second valid/ready handshake.
- Sits between a word producer (register file or counter) and control logic that needs an ordered compare without a WIDTH-wide comparator.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk.
- in_valid  input  1  a/b pair present.
- in_ready  output  1  block can accept a pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- eq  output  1  a == b.
- gt  output  1  a > b.
- lt  output  1  a < b.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: rst_n low at a rising edge forces the following on the next cycle:
  - state = IDLE, shift registers and counter = 0.
  - in_ready = 1.
  - out_valid, eq, gt, lt, busy = 0.
- Reset asserted mid-operation (SHIFT or DONE) discards the pair in flight; no result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T0: capture a and b into shift registers sa and sb, load counter with WIDTH, go to SHIFT.
  - in_valid without in_ready has no effect. Inputs are sampled only at the accepting edge; later changes to a and b are ignored.
- SHIFT:
  - in_ready = 0.
  - At each edge, compare sa[WIDTH-1] with sb[WIDTH-1] through the bit cell.
  - Bits differ: register gt = sa msb, lt = sb msb, eq = 0, go to DONE.
  - Bits equal and counter == 1: register eq = 1, gt = lt = 0, go to DONE.
  - Otherwise: shift sa and sb left by 1, fill with 0, decrement the counter.
- Latency: out_valid rises at edge T0+k, where k = 1 + (number of leading equal bits) when the words differ, and k = WIDTH when they are equal. Maximum latency is WIDTH cycles; minimum is 1.
- DONE:
  - out_valid = 1; eq/gt/lt hold stable and exactly one is high.
  - On out_valid & out_ready: clear eq/gt/lt and out_valid, go to IDLE.
  - A new pair can be accepted no earlier than the edge after the result handshake, so throughput is at most one pair per k+2 cycles.
  - Backpressure (out_ready low) holds DONE indefinitely with outputs unchanged.
- eq/gt/lt are 0 whenever out_valid is 0.
- out_ready is ignored outside DONE.
- Boundary operands: 0 vs 0 and all-ones vs all-ones give eq after WIDTH cycles. 0 vs 1 gives lt after WIDTH cycles (difference in the LSB). A difference in the MSB gives a decision after 1 cycle.
- Counter width: $clog2(WIDTH+1). The counter never underflows because the equal case exits at counter == 1.

Decomposition:
- Package serial_mag_comp_pkg holds:
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH constant.
  - A function computing the counter width.
- One natural sub-module: cmp_bit_cell, purely combinational.
  - Inputs: x, y. Outputs: e = (~x & ~y) | (x & y), g = x & ~y.
  - One instance, driven by the shift-register MSBs.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release -> in_ready=1, out_valid=0, eq=gt=lt=0, busy=0.
- MSB difference, early exit: a=8'h80, b=8'h7F accepted at T0 -> out_valid=1 at T0+1, gt=1, eq=lt=0. Swapping operands -> lt=1.
- Full-length equal: a=b=8'hA5 -> out_valid at T0+8, eq=1. Repeat with 8'h00/8'h00 and 8'hFF/8'hFF -> eq at T0+8.
- LSB difference: a=8'h10, b=8'h11 -> out_valid at T0+8, lt=1. Then a=8'h3C, b=8'h34 -> gt at T0+5.
- Backpressure and no overlap: hold out_ready=0 for 10 cycles after the result -> outputs stable and in_ready=0 throughout. Raise out_ready -> IDLE on the next edge. Assert in_valid continuously -> the next pair is accepted only once in_ready=1.
- Reset mid-operation: pulse rst_n low at T0+3 of an 8-cycle equal compare -> no out_valid ever for that pair, in_ready=1 one cycle after the reset edge. A fresh pair 8'h01 vs 8'h02 -> lt at T0'+7.
